// File: rtl/io_bridge_if.sv
// Bus interface between the core/external agents and io_bridge.
// The bridge uses the slave modport; the driving side uses master.
interface io_bridge_if #(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUIOIN = 8,
  parameter int unsigned NUIOOU = 8
);
  localparam int unsigned AIW = $clog2(NUIOIN);
  localparam int unsigned AOW = $clog2(NUIOOU);

  logic [NUBITS-1:0] io_in;
  logic [AIW-1:0]    addr_in;
  logic              req_in;
  logic [NUBITS-1:0] data_out;
  logic [AOW-1:0]    addr_out;
  logic              out_en;
  logic              ext_in_valid;
  logic [AIW-1:0]    ext_in_addr;
  logic [NUBITS-1:0] ext_in_data;
  logic              ext_in_ready;
  logic              ext_out_valid;
  logic [AOW-1:0]    ext_out_addr;
  logic [NUBITS-1:0] ext_out_data;
  logic              ext_out_ready;

  modport slave (
    output io_in, ext_in_ready, ext_out_valid, ext_out_addr, ext_out_data,
    input  addr_in, req_in, data_out, addr_out, out_en,
    input  ext_in_valid, ext_in_addr, ext_in_data, ext_out_ready
  );

  modport master (
    input  io_in, ext_in_ready, ext_out_valid, ext_out_addr, ext_out_data,
    output addr_in, req_in, data_out, addr_out, out_en,
    output ext_in_valid, ext_in_addr, ext_in_data, ext_out_ready
  );
endinterface

// File: rtl/io_bridge.sv
// I/O bus responder: per-port input holding registers and an output {addr,data} FIFO.
// Optional macro IOB_ERRCNT_EN adds saturating overflow/underflow event counters.
module io_bridge #(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUIOIN = 8,
  parameter int unsigned NUIOOU = 8,
  parameter int unsigned FDEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  io_bridge_if.slave        bus,
  output logic [NUIOIN-1:0] o_in_full,
  output logic              o_ovf,
  output logic              o_udf
`ifdef IOB_ERRCNT_EN
  ,
  output logic [7:0]        o_ovf_cnt,
  output logic [7:0]        o_udf_cnt
`endif
);
  localparam int unsigned AIW   = $clog2(NUIOIN);
  localparam int unsigned AOW   = $clog2(NUIOOU);
  localparam int unsigned DEPTH = 1 << FDEPTH;

  // ---------------- input side ----------------
  logic [NUBITS-1:0] r_hold [NUIOIN];
  logic [NUIOIN-1:0] r_full;
  logic [NUIOIN-1:0] w_full_d;
  logic              w_load;
  logic              w_empty_rd;

  assign bus.ext_in_ready = ~r_full[bus.ext_in_addr];
  assign w_load           = bus.ext_in_valid & bus.ext_in_ready;
  assign w_empty_rd       = bus.req_in & ~r_full[bus.addr_in];
  assign bus.io_in        = r_hold[bus.addr_in];
  assign o_in_full        = r_full;

  // Consume clears first so a same-edge load on the same port leaves it full.
  always_comb begin
    w_full_d = r_full;
    if (bus.req_in) w_full_d[bus.addr_in] = 1'b0;
    if (w_load)     w_full_d[bus.ext_in_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      for (int i = 0; i < int'(NUIOIN); i++) r_hold[i] <= '0;
    end else begin
      r_full <= w_full_d;
      for (int i = 0; i < int'(NUIOIN); i++) begin
        if (w_load && (bus.ext_in_addr == AIW'(i))) r_hold[i] <= bus.ext_in_data;
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [AOW-1:0]    r_mem_addr [DEPTH];
  logic [NUBITS-1:0] r_mem_data [DEPTH];
  logic [FDEPTH-1:0] r_wptr;
  logic [FDEPTH-1:0] r_rptr;
  logic [FDEPTH-1:0] w_rptr_nx;
  logic [FDEPTH:0]   r_count;
  logic [FDEPTH:0]   w_count_d;
  logic [AOW-1:0]    r_head_addr;
  logic [AOW-1:0]    w_head_addr_d;
  logic [NUBITS-1:0] r_head_data;
  logic [NUBITS-1:0] w_head_data_d;
  logic              w_fifo_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_fifo_full       = (r_count == (FDEPTH+1)'(DEPTH));
  assign w_pop             = (r_count != '0) & bus.ext_out_ready;
  assign w_push            = bus.out_en & (~w_fifo_full | w_pop);
  assign w_drop            = bus.out_en & w_fifo_full & ~w_pop;
  assign w_rptr_nx         = r_rptr + 1'b1;
  assign bus.ext_out_valid = (r_count != '0);
  assign bus.ext_out_addr  = r_head_addr;
  assign bus.ext_out_data  = r_head_data;

  // Head register is preloaded so the next entry is visible the cycle after a pop;
  // a push into an empty (or just-emptied) FIFO bypasses the memory.
  always_comb begin
    w_count_d     = r_count;
    w_head_addr_d = r_head_addr;
    w_head_data_d = r_head_data;
    if (w_push && !w_pop)      w_count_d = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_d = r_count - 1'b1;
    if (w_pop) begin
      if (r_count > (FDEPTH+1)'(1)) begin
        w_head_addr_d = r_mem_addr[w_rptr_nx];
        w_head_data_d = r_mem_data[w_rptr_nx];
      end else if (w_push) begin
        w_head_addr_d = bus.addr_out;
        w_head_data_d = bus.data_out;
      end
    end else if ((r_count == '0) && w_push) begin
      w_head_addr_d = bus.addr_out;
      w_head_data_d = bus.data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= bus.addr_out;
      r_mem_data[r_wptr] <= bus.data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_head_addr <= '0;
      r_head_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= w_rptr_nx;
      r_count     <= w_count_d;
      r_head_addr <= w_head_addr_d;
      r_head_data <= w_head_data_d;
    end
  end

  // ---------------- sticky error flags ----------------
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_drop)     r_ovf <= 1'b1;
      if (w_empty_rd) r_udf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
  assign o_udf = r_udf;

`ifdef IOB_ERRCNT_EN
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_udf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else begin
      if (w_drop && (r_ovf_cnt != 8'hFF))     r_ovf_cnt <= r_ovf_cnt + 8'd1;
      if (w_empty_rd && (r_udf_cnt != 8'hFF)) r_udf_cnt <= r_udf_cnt + 8'd1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
  assign o_udf_cnt = r_udf_cnt;
`endif
endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: input-side vector table plus hand-written FIFO sequences.
module tb_io_bridge;
  localparam int unsigned NUBITS = 32;
  localparam int unsigned NUIOIN = 8;
  localparam int unsigned NUIOOU = 8;
  localparam int unsigned FDEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_full;
  logic        ovf;
  logic        udf;
`ifdef IOB_ERRCNT_EN
  logic [7:0]  ovf_cnt;
  logic [7:0]  udf_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  io_bridge_if #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU)) bus ();

  io_bridge #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .o_in_full (in_full),
    .o_ovf     (ovf),
    .o_udf     (udf)
`ifdef IOB_ERRCNT_EN
    ,
    .o_ovf_cnt (ovf_cnt),
    .o_udf_cnt (udf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  la;
    logic [31:0] ldata;
    logic        rq;
    logic [2:0]  ra;
    logic [31:0] exp_io;
    logic        exp_rdy;
    logic [7:0]  exp_full;
    logic        exp_udf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.addr_in       = '0;
    bus.req_in        = 1'b0;
    bus.data_out      = '0;
    bus.addr_out      = '0;
    bus.out_en        = 1'b0;
    bus.ext_in_valid  = 1'b0;
    bus.ext_in_addr   = '0;
    bus.ext_in_data   = '0;
    bus.ext_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [2:0] a, input logic [31:0] d);
    bus.out_en   = 1'b1;
    bus.addr_out = a;
    bus.data_out = d;
    step();
    bus.out_en   = 1'b0;
  endtask

  initial begin
    //               ld  la  ldata          rq  ra  exp_io         rdy  full   udf
    tbl[0] = '{1'b1, 3'd3, 32'h0000_1234, 1'b0, 3'd3, 32'h0,         1'b1, 8'h08, 1'b0};
    tbl[1] = '{1'b0, 3'd3, 32'h0,         1'b1, 3'd3, 32'h0000_1234, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 3'd5, 32'h0,         1'b1, 3'd5, 32'h0,         1'b1, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 3'd2, 32'h55,        1'b0, 3'd2, 32'h0,         1'b1, 8'h04, 1'b1};
    tbl[4] = '{1'b0, 3'd2, 32'h0,         1'b1, 3'd2, 32'h55,        1'b0, 8'h00, 1'b1};
    tbl[5] = '{1'b1, 3'd2, 32'hAA,        1'b1, 3'd2, 32'h55,        1'b1, 8'h04, 1'b1};
    tbl[6] = '{1'b0, 3'd2, 32'h0,         1'b1, 3'd2, 32'hAA,        1'b0, 8'h00, 1'b1};
    tbl[7] = '{1'b1, 3'd7, 32'hDEAD_BEEF, 1'b0, 3'd7, 32'h0,         1'b1, 8'h80, 1'b1};
    // Load to a full port must be refused while the consume still sees the old word.
    tbl[8] = '{1'b1, 3'd7, 32'h1111,      1'b1, 3'd7, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b1};

    do_reset();

    // Reset state
    chk("rst_out_valid", 64'(bus.ext_out_valid), 64'd0);
    chk("rst_out_addr", 64'(bus.ext_out_addr), 64'd0);
    chk("rst_out_data", 64'(bus.ext_out_data), 64'd0);
    chk("rst_in_full", 64'(in_full), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_udf", 64'(udf), 64'd0);
    for (int p = 0; p < 8; p++) begin
      bus.ext_in_addr = 3'(p);
      #1;
      chk($sformatf("rst_ready_p%0d", p), 64'(bus.ext_in_ready), 64'd1);
    end
    step();

    // Input-side vector table
    for (int v = 0; v < 9; v++) begin
      bus.ext_in_valid = tbl[v].ld;
      bus.ext_in_addr  = tbl[v].la;
      bus.ext_in_data  = tbl[v].ldata;
      bus.req_in       = tbl[v].rq;
      bus.addr_in      = tbl[v].ra;
      #1;
      chk($sformatf("v%0d_io_in", v), 64'(bus.io_in), 64'(tbl[v].exp_io));
      chk($sformatf("v%0d_ready", v), 64'(bus.ext_in_ready), 64'(tbl[v].exp_rdy));
      step();
      bus.ext_in_valid = 1'b0;
      bus.req_in       = 1'b0;
      chk($sformatf("v%0d_in_full", v), 64'(in_full), 64'(tbl[v].exp_full));
      chk($sformatf("v%0d_udf", v), 64'(udf), 64'(tbl[v].exp_udf));
    end
    bus.addr_in = 3'd7;
    #1;
    chk("p7_not_overwritten", 64'(bus.io_in), 64'hDEAD_BEEF);
    bus.addr_in = 3'd2;
    #1;
    chk("p2_holds_aa", 64'(bus.io_in), 64'hAA);
`ifdef IOB_ERRCNT_EN
    chk("udf_cnt", 64'(udf_cnt), 64'd2);
`endif
    chk("ovf_still_clear", 64'(ovf), 64'd0);

    // Fill past capacity with the consumer stalled, then drain in order
    for (int i = 0; i < 9; i++) begin
      push_word(3'(i), 32'(i + 100));
      if (i == 0) begin
        chk("first_word_valid", 64'(bus.ext_out_valid), 64'd1);
        chk("first_word_data", 64'(bus.ext_out_data), 64'd100);
      end
      if (i == 7) chk("ovf_clear_at_8", 64'(ovf), 64'd0);
    end
    chk("ovf_after_9", 64'(ovf), 64'd1);
`ifdef IOB_ERRCNT_EN
    chk("ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
    bus.ext_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(bus.ext_out_valid), 64'd1);
      chk($sformatf("drain%0d_addr", k), 64'(bus.ext_out_addr), 64'(k));
      chk($sformatf("drain%0d_data", k), 64'(bus.ext_out_data), 64'(k + 100));
      step();
    end
    chk("drain_empty", 64'(bus.ext_out_valid), 64'd0);
    bus.ext_out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop: nothing dropped
    do_reset();
    for (int i = 0; i < 8; i++) push_word(3'(i), 32'(i + 100));
    bus.ext_out_ready = 1'b1;
    push_word(3'd5, 32'd200);
    bus.ext_out_ready = 1'b0;
    chk("pp_ovf", 64'(ovf), 64'd0);
    chk("pp_head", 64'(bus.ext_out_data), 64'd101);
    bus.ext_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pp%0d_valid", k), 64'(bus.ext_out_valid), 64'd1);
      chk($sformatf("pp%0d_data", k), 64'(bus.ext_out_data), (k == 7) ? 64'd200 : 64'(k + 101));
      step();
    end
    chk("pp_count8_empty", 64'(bus.ext_out_valid), 64'd0);
    bus.ext_out_ready = 1'b0;

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 4; i++) push_word(3'(i), 32'(i + 300));
    bus.ext_out_ready = 1'b1;
    step();
    chk("mid_head", 64'(bus.ext_out_data), 64'd301);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.ext_out_valid), 64'd0);
    chk("arst_data", 64'(bus.ext_out_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", 64'(bus.ext_out_valid), 64'd0);
    chk("post_rst_ovf", 64'(ovf), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
